instruction_encode_loader: RTL and testbench
============================================

INSTRUCTION_ENCODE_LOADER -- requirements
Module: instruction_encode_loader

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset, both listed first: clk input 1 (rising-edge clock); rst_n input 1 (synchronous active-low reset).
REQ-002 SHALL have the control ports:
- start input 1: begin load session
- base_addr input 32: first write address
- done output 1: session complete
- err output 1: sticky illegal-format flag
- count output 16: words written this session
REQ-003 SHALL have the input handshake ports:
- in_valid input 1: field bundle valid
- in_ready output 1: block can accept a bundle
- in_last input 1: final instruction of session
REQ-004 SHALL have the field ports:
- fmt input 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 illegal
- opcode input 7; rd input 5; funct3 input 3; rs1 input 5; rs2 input 5; funct7 input 7
- imm input 32: immediate, pre-sign-extended
REQ-005 SHALL have the memory ports:
- mem_we output 1: write strobe
- mem_addr output 32: word address
- mem_wdata output 32: encoded instruction
- mem_ready input 1: memory accepts write

Function
REQ-006 SHALL implement FSM states IDLE, RUN, WRITE and DONE.
REQ-007 IDLE and DONE: start=1 SHALL load addr=base_addr and count=0, clear err, and go to RUN; otherwise SHALL hold state.
REQ-008 SHALL drive in_ready=1 only in RUN; done=1 only in DONE; mem_we=1 only in WRITE.
REQ-009 SHALL accept a bundle in RUN on in_valid&in_ready; an accepted bundle with fmt 0-5 SHALL register mem_wdata=encode(fields) and mem_addr=addr, latch in_last, and go to WRITE the next cycle.
REQ-010 An accepted bundle with fmt 6 or 7 SHALL set err, write nothing, leave count and addr unchanged, and stay in RUN; in_last on that bundle SHALL still move to DONE.
REQ-011 SHALL assert mem_we the cycle after acceptance; latency is 1 cycle; minimum throughput is 1 word per 2 cycles.
REQ-012 WRITE SHALL hold mem_we, mem_addr and mem_wdata stable until mem_ready=1; on mem_ready it SHALL set addr+=4 and count+=1 and go to DONE if in_last was latched, else to RUN.
REQ-013 addr SHALL wrap mod 2^32 (0xFFFFFFFC -> 0x00000000); count SHALL wrap mod 2^16.
REQ-014 in_valid, start and in_last SHALL be ignored in any state where they are not defined above; start during RUN or WRITE SHALL be ignored.
REQ-015 Encoding; shown fields are bit ranges of the 32-bit word, MSB first:
- R: funct7|rs2|rs1|funct3|rd|opcode
- I: imm[11:0]|rs1|funct3|rd|opcode
- S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
- B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
- U: imm[31:12]|rd|opcode
- J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
REQ-016 Unused fields per format SHALL be ignored; imm[0] SHALL be ignored for B and J.

Reset
REQ-017 rst_n=0 at a clock edge SHALL force IDLE, in_ready=0, done=0, err=0, count=0, mem_we=0, mem_addr=0 and mem_wdata=0, overriding all other inputs in any state.
REQ-018 Reset asserted mid-WRITE SHALL drop mem_we the next cycle with no addr or count update.

Verification
REQ-019 Reset, start with base_addr=0x100, then I fmt (opcode 0x13, rd 1, rs1 0, funct3 0, imm 5) -> mem_wdata=0x00500093, mem_addr=0x100, mem_we 1 cycle after acceptance.
REQ-020 Back-to-back R fmt (opcode 0x33, rd 3, rs1 1, rs2 2) then S fmt (opcode 0x23, funct3 2, rs1 1, rs2 2, imm 8), in_last on the second -> words 0x002081B3 @0x100 and 0x0020A423 @0x104, done=1, count=2.
REQ-021 B fmt (opcode 0x63, imm 0xFFFFFFFC, others 0) -> 0xFE000EE3; J fmt (opcode 0x6F, rd 1, imm 8) -> 0x008000EF.
REQ-022 mem_ready held 0 for 3 cycles in WRITE -> mem_we, mem_addr and mem_wdata stable throughout, in_ready=0, one write only.
REQ-023 fmt=7 bundle -> err=1, no mem_we, count unchanged; next start clears err.
REQ-024 base_addr=0xFFFFFFFC with two writes -> addresses 0xFFFFFFFC then 0x00000000; rst_n=0 during WRITE -> mem_we=0 next cycle, count=0.

Source files
------------

// File: rtl/instruction_encode_loader.sv
// rtl/instruction_encode_loader.sv - RV32 field-bundle encoder that streams encoded words into instruction memory
module instruction_encode_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  output logic        done,
  output logic        err,
  output logic [15:0] count,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr;
  logic [31:0] enc_word;
  logic        last_q;
  logic        legal;

  assign legal = (fmt <= 3'd5);

  always_comb begin
    enc_word = '0;
    case (fmt)
      3'd0: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      3'd2: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'd3: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'd4: enc_word = {imm[31:12], rd, opcode};
      3'd5: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        // an illegal bundle is dropped but its in_last still closes the session
        if (in_valid) begin
          if (legal)        state_nxt = WRITE;
          else if (in_last) state_nxt = DONE;
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        if (mem_ready) state_nxt = last_q ? DONE : RUN;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      count     <= '0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            addr  <= base_addr;
            count <= '0;
            err   <= 1'b0;
          end
        end
        RUN: begin
          if (in_valid) begin
            if (legal) begin
              mem_wdata <= enc_word;
              mem_addr  <= addr;
              last_q    <= in_last;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            addr  <= addr + 32'd4;
            count <= count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encode_loader.sv
// tb/tb_instruction_encode_loader.sv - directed plus randomized checks of instruction_encode_loader
module tb_instruction_encode_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        done;
  logic        err;
  logic [15:0] count;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;

  logic [31:0] addr_m;
  logic [15:0] count_m;
  logic        err_m;

  always #5 clk = ~clk;

  instruction_encode_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .done(done), .err(err), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
    .rs2(rs2), .funct7(funct7), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoding built from bit positions with shifts and masks
  function automatic logic [31:0] encode_ref(input logic [31:0] f, op, rdv, f3, r1, r2, f7, im);
    logic [31:0] w;
    w = op | (f3 << 12) | (r1 << 15);
    case (f)
      0: w = w | (rdv << 7) | (r2 << 20) | (f7 << 25);
      1: w = w | (rdv << 7) | ((im & 32'hFFF) << 20);
      2: w = w | ((im & 31) << 7) | (r2 << 20) | (((im >> 5) & 127) << 25);
      3: w = w | (((im >> 11) & 1) << 7) | (((im >> 1) & 15) << 8) | (r2 << 20)
               | (((im >> 5) & 63) << 25) | (((im >> 12) & 1) << 31);
      4: w = op | (rdv << 7) | (im & 32'hFFFFF000);
      5: w = op | (rdv << 7) | (im & 32'h000FF000) | (((im >> 11) & 1) << 20)
               | (((im >> 1) & 1023) << 21) | (((im >> 20) & 1) << 31);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  task automatic setf(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rdv,
                      input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = rdv; funct3 = f3; rs1 = r1; rs2 = r2; funct7 = f7; imm = im;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    addr_m = 0; count_m = 0; err_m = 0;
  endtask

  task automatic start_session(input logic [31:0] base);
    start = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
    base_addr = 32'h0;
    addr_m = base; count_m = 0; err_m = 0;
    chk("start_in_ready", in_ready, 1);
    chk("start_err", err, 0);
    chk("start_count", count, 0);
    chk("start_done", done, 0);
  endtask

  // Offer one bundle; exp_w is the required word for legal formats.
  task automatic send(input logic lst, input int stall, input logic [31:0] exp_w);
    int n;
    logic legal_m;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    legal_m = (fmt <= 3'd5);
    in_valid = 1'b1;
    in_last = lst;
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    if (legal_m) begin
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, addr_m);
      chk("wr_mem_wdata", mem_wdata, exp_w);
      chk("wr_in_ready", in_ready, 0);
      for (int i = 0; i < stall; i++) begin
        start = 1'b1;
        base_addr = ~addr_m;
        @(negedge clk);
        chk("stall_mem_we", mem_we, 1);
        chk("stall_mem_addr", mem_addr, addr_m);
        chk("stall_mem_wdata", mem_wdata, exp_w);
        chk("stall_in_ready", in_ready, 0);
      end
      start = 1'b0;
      base_addr = 32'h0;
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      addr_m = addr_m + 32'd4;
      count_m = count_m + 16'd1;
      chk("post_mem_we", mem_we, 0);
    end else begin
      err_m = 1'b1;
      chk("ill_mem_we", mem_we, 0);
    end
    chk("count", count, count_m);
    chk("err", err, err_m);
    chk("done", done, lst);
    chk("in_ready_after", in_ready, !lst);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    mem_ready = 1'b0;
    setf(0, 0, 0, 0, 0, 0, 0, 0);
    addr_m = 0; count_m = 0; err_m = 0;

    do_reset();

    // I-type at 0x100, then R and S back to back closing the session
    start_session(32'h100);
    setf(1, 7'h13, 1, 0, 0, 0, 0, 32'd5);
    send(1'b0, 0, 32'h00500093);
    chk("i_addr_next", addr_m, 32'h104);
    do_reset();
    start_session(32'h100);
    setf(0, 7'h33, 3, 0, 1, 2, 0, 0);
    send(1'b0, 0, 32'h002081B3);
    setf(2, 7'h23, 0, 2, 1, 2, 0, 32'd8);
    send(1'b1, 0, 32'h0020A423);
    chk("rs_count", count, 16'd2);

    // B and J with stalled memory and start ignored while writing
    start_session(32'h200);
    setf(3, 7'h63, 0, 0, 0, 0, 0, 32'hFFFFFFFC);
    send(1'b0, 3, 32'hFE000EE3);
    setf(5, 7'h6F, 1, 0, 0, 0, 0, 32'd8);
    send(1'b0, 2, 32'h008000EF);

    // illegal format sets err, writes nothing; illegal last still ends session
    setf(7, 7'h13, 1, 0, 0, 0, 0, 32'd1);
    send(1'b0, 0, 32'h0);
    setf(6, 7'h13, 1, 0, 0, 0, 0, 32'd1);
    send(1'b1, 0, 32'h0);
    chk("ill_count", count, 16'd2);
    start_session(32'h300);

    // address wrap
    do_reset();
    start_session(32'hFFFFFFFC);
    setf(4, 7'h37, 5, 0, 0, 0, 0, 32'hABCDE123);
    send(1'b0, 1, 32'hABCDE2B7);
    chk("wrap_addr_model", addr_m, 32'h0);
    setf(1, 7'h13, 2, 0, 3, 0, 0, 32'hFFFFFFFF);
    send(1'b0, 0, encode_ref(1, 7'h13, 2, 0, 3, 0, 0, 32'hFFFFFFFF));

    // reset while a write is pending
    setf(0, 7'h33, 4, 1, 5, 6, 7'h20, 0);
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_mem_we", mem_we, 1);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    addr_m = 0; count_m = 0; err_m = 0;
    @(negedge clk);
    chk("idle_hold", in_ready, 0);

    // randomized sessions against the reference encoder
    for (int s = 0; s < 8; s++) begin
      int nb;
      start_session($urandom);
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        setf(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 3'($urandom),
             5'($urandom), 5'($urandom), 7'($urandom), $urandom);
        send(b == nb - 1, $urandom_range(0, 3),
             encode_ref(fmt, opcode, rd, funct3, rs1, rs2, funct7, imm));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
